wr_req_splitter: RTL and testbench
==================================

Name: wr_req_splitter

Overview:
- Upstream stage of the NoC write-request module.
- Takes one arbitrary-length write request (flit-aligned address, byte size) plus its data stream from a client engine.
- Emits a sequence of sub-requests, each confined to one MAX_CHUNK_BYTES-aligned window, with a re-framed data stream (last/padbytes per sub-request).
- Collects one downstream write-done per sub-request and returns a single done to the client.

Parameters:
- MAX_CHUNK_BYTES, 256, max bytes per sub-request and alignment of its window; power of 2, ≥ NOC_DATA_BYTES.
- REQ_SIZE_W, 16, width of the client size field; sub-request size fits in mem_req_struct.mem_req_size.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- client_wr_req_val  in  1  client request valid
- client_wr_req_addr  in  width of mem_req_addr  start byte address; flit-aligned
- client_wr_req_size  in  REQ_SIZE_W  total bytes
- wr_req_client_rdy  out  1  request accepted
- client_wr_data_val  in  1  data flit valid
- client_wr_data  in  NOC_DATA_WIDTH  data flit
- client_wr_data_last  in  1  last flit of whole request
- client_wr_data_padbytes  in  NOC_PADBYTES_WIDTH  pad bytes on last flit
- wr_data_client_rdy  out  1  data flit consumed
- split_wr_req_val  out  1  sub-request valid
- split_wr_req_entry  out  mem_req_struct  sub-request addr/size
- wr_req_split_rdy  in  1  downstream accepts sub-request
- split_wr_data_val  out  1  sub-request data valid
- split_wr_data  out  NOC_DATA_WIDTH  data passthrough
- split_wr_data_last  out  1  last flit of sub-request
- split_wr_data_padbytes  out  NOC_PADBYTES_WIDTH  pad bytes on sub-request last flit, else 0
- wr_split_data_rdy  in  1  downstream accepts data
- split_done_val  in  1  downstream sub-request done
- split_done_rdy  out  1  accept downstream done
- client_wr_done  out  1  whole request complete
- client_wr_done_rdy  in  1  client accepts done

Behaviour:
- Reset: state IDLE; counters/regs 0. All outputs 0 except wr_req_client_rdy = 1 in IDLE.
- States: IDLE, ISSUE_REQ, STREAM_DATA, WAIT_DONE, OUTPUT_DONE.
- IDLE:
  - wr_req_client_rdy = 1.
  - On val: latch addr_reg = addr, remain_reg = size.
  - size == 0: go to OUTPUT_DONE (no sub-request).
  - Otherwise: go to ISSUE_REQ.
- Chunk size (combinational from regs): chunk = min(remain_reg, MAX_CHUNK_BYTES − (addr_reg & (MAX_CHUNK_BYTES−1))).
- Flit count: nflits = ceil(chunk / NOC_DATA_BYTES).
- Pad bytes: pad = nflits·NOC_DATA_BYTES − chunk.
- ISSUE_REQ:
  - split_wr_req_val = 1; entry = {addr_reg, chunk}, other fields 0; values held stable while val.
  - On rdy: latch chunk_reg, nflits_reg, pad_reg; flit_cnt = 0; go to STREAM_DATA.
- STREAM_DATA:
  - Pure combinational pass-through: split_wr_data_val = client_wr_data_val; wr_data_client_rdy = wr_split_data_rdy.
  - split_wr_data_last = (flit_cnt == nflits_reg−1).
  - split_wr_data_padbytes = last ? pad_reg : 0.
  - On each val&rdy, flit_cnt++.
  - On last transfer: addr_reg += chunk_reg, remain_reg −= chunk_reg; go to WAIT_DONE.
- WAIT_DONE:
  - split_done_rdy = 1.
  - On split_done_val: remain_reg == 0 → OUTPUT_DONE, else → ISSUE_REQ.
- OUTPUT_DONE: client_wr_done = 1 until client_wr_done_rdy, then IDLE.
- Only one sub-request in flight at a time; no new client request is accepted before done is handshaken.
- Address/remain arithmetic is full width; address wrap past top is not supported.
- split_done_val outside WAIT_DONE is ignored (rdy = 0).
- Reset mid-operation: returns to IDLE next cycle; any partial transfer is abandoned.
- Client padbytes/last are not used for framing (size is authoritative); they are only checked under the optional feature.

Optional Feature:
- Macro WR_SPLIT_CHECK_EN.
- Defined: adds output split_err (1 bit, sticky, cleared by rst). Set when:
  - client_wr_data_last arrives on a flit other than the final flit of the final chunk;
  - the final flit lacks last;
  - client padbytes ≠ pad_reg on the final flit;
  - the request address is not flit-aligned.
- Undefined: port and checking logic absent; framing behaviour identical.

Decomposition:
- Add to noc_struct_pkg: state enum wr_split_state_e; a constant-width helper type for the chunk size.
- Sub-module wr_split_chunk_calc (combinational: chunk, nflits, pad from addr_reg/remain_reg) keeps the FSM file small; the FSM lives in wr_req_splitter.

Test Plan:
NOC_DATA_WIDTH = 512 (64 B/flit), MAX_CHUNK_BYTES = 256.
- addr 0x000, size 128 -> one sub-request {0x000, 128}; 2 flits, last on 2nd, padbytes 0; client_wr_done after 1 split_done.
- addr 0x0C0, size 320 -> sub-requests {0x0C0, 64} (1 flit, last) then {0x100, 256} (4 flits); client_wr_done only after 2nd split_done.
- addr 0x040, size 100 -> {0x040, 100}; 2 flits; 2nd flit last, padbytes 28.
- size 0 -> no split_wr_req_val; client_wr_done asserted the cycle after acceptance.
- Random wr_split_data_rdy/client_wr_data_val stalls, client_wr_done_rdy held low 5 cycles -> data order/count intact, done held steady, wr_req_client_rdy = 0 throughout.
- rst pulsed during 3rd flit of a 4-flit chunk -> IDLE next cycle, all valids 0; next request {0x200, 64} completes normally.

Source files
------------

// File: rtl/wr_req_splitter_pkg.sv
// wr_req_splitter_pkg
//   Shared types and constants for the write-request splitter slice:
//   NoC flit geometry, the memory request entry handed downstream,
//   the splitter state enum and a fixed-width chunk-size type.
//   Imported by the interfaces, wr_split_chunk_calc and wr_req_splitter.

package wr_req_splitter_pkg;

  localparam int NOC_DATA_WIDTH     = 512;
  localparam int NOC_DATA_BYTES     = NOC_DATA_WIDTH / 8;
  localparam int NOC_PADBYTES_WIDTH = $clog2(NOC_DATA_BYTES);

  localparam int MEM_ADDR_W = 32;
  localparam int MEM_SIZE_W = 16;
  localparam int MEM_ID_W   = 8;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] mem_req_addr;
    logic [MEM_SIZE_W-1:0] mem_req_size;
    logic [MEM_ID_W-1:0]   mem_req_id;
  } mem_req_struct;

  // Chunk sizes and flit counts share one width so they drop straight
  // into mem_req_size without further casting.
  typedef logic [MEM_SIZE_W-1:0] chunk_size_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_REQ,
    STREAM_DATA,
    WAIT_DONE,
    OUTPUT_DONE
  } wr_split_state_e;

  function automatic logic flit_aligned(input logic [MEM_ADDR_W-1:0] addr);
    return addr[NOC_PADBYTES_WIDTH-1:0] == '0;
  endfunction

endpackage

// File: rtl/wr_req_splitter_if.sv
// wr_client_if / wr_split_if
//   wr_client_if : client engine <-> splitter (request, data stream, done).
//                  master = client engine, slave = splitter.
//   wr_split_if  : splitter <-> downstream write stage (sub-request,
//                  re-framed data stream, per-sub-request done).
//                  master = splitter, slave = downstream stage.

interface wr_client_if
  import wr_req_splitter_pkg::*;
#(
  parameter int REQ_SIZE_W = 16
);
  logic                          client_wr_req_val;
  logic [MEM_ADDR_W-1:0]         client_wr_req_addr;
  logic [REQ_SIZE_W-1:0]         client_wr_req_size;
  logic                          wr_req_client_rdy;
  logic                          client_wr_data_val;
  logic [NOC_DATA_WIDTH-1:0]     client_wr_data;
  logic                          client_wr_data_last;
  logic [NOC_PADBYTES_WIDTH-1:0] client_wr_data_padbytes;
  logic                          wr_data_client_rdy;
  logic                          client_wr_done;
  logic                          client_wr_done_rdy;

  modport master (
    output client_wr_req_val, client_wr_req_addr, client_wr_req_size,
    output client_wr_data_val, client_wr_data, client_wr_data_last,
    output client_wr_data_padbytes, client_wr_done_rdy,
    input  wr_req_client_rdy, wr_data_client_rdy, client_wr_done
  );

  modport slave (
    input  client_wr_req_val, client_wr_req_addr, client_wr_req_size,
    input  client_wr_data_val, client_wr_data, client_wr_data_last,
    input  client_wr_data_padbytes, client_wr_done_rdy,
    output wr_req_client_rdy, wr_data_client_rdy, client_wr_done
  );
endinterface

interface wr_split_if
  import wr_req_splitter_pkg::*;
;
  logic                          split_wr_req_val;
  mem_req_struct                 split_wr_req_entry;
  logic                          wr_req_split_rdy;
  logic                          split_wr_data_val;
  logic [NOC_DATA_WIDTH-1:0]     split_wr_data;
  logic                          split_wr_data_last;
  logic [NOC_PADBYTES_WIDTH-1:0] split_wr_data_padbytes;
  logic                          wr_split_data_rdy;
  logic                          split_done_val;
  logic                          split_done_rdy;

  modport master (
    output split_wr_req_val, split_wr_req_entry,
    output split_wr_data_val, split_wr_data, split_wr_data_last,
    output split_wr_data_padbytes, split_done_rdy,
    input  wr_req_split_rdy, wr_split_data_rdy, split_done_val
  );

  modport slave (
    input  split_wr_req_val, split_wr_req_entry,
    input  split_wr_data_val, split_wr_data, split_wr_data_last,
    input  split_wr_data_padbytes, split_done_rdy,
    output wr_req_split_rdy, wr_split_data_rdy, split_done_val
  );
endinterface

// File: rtl/wr_split_chunk_calc.sv
// wr_split_chunk_calc
//   Combinational sizing of the next sub-request from the splitter's
//   current address and remaining byte count.
//   Ports:
//     addr   in  current byte address (flit-aligned)
//     remain in  bytes still to be written
//     chunk  out bytes in this sub-request (never crosses a window)
//     nflits out flits needed to carry chunk
//     pad    out unused bytes on the final flit of the chunk

module wr_split_chunk_calc
  import wr_req_splitter_pkg::*;
#(
  parameter int MAX_CHUNK_BYTES = 256,
  parameter int REQ_SIZE_W      = 16
) (
  input  logic [MEM_ADDR_W-1:0]         addr,
  input  logic [REQ_SIZE_W-1:0]         remain,
  output chunk_size_t                   chunk,
  output chunk_size_t                   nflits,
  output logic [NOC_PADBYTES_WIDTH-1:0] pad
);

  localparam int OFF_W  = $clog2(MAX_CHUNK_BYTES);
  // Two spare bits: one so MAX_CHUNK_BYTES itself is representable,
  // one so the round-up to a whole flit cannot overflow.
  localparam int CALC_W = ((REQ_SIZE_W > OFF_W) ? REQ_SIZE_W : OFF_W) + 2;

  logic [CALC_W-1:0] room;
  logic [CALC_W-1:0] remain_ext;
  logic [CALC_W-1:0] chunk_ext;
  logic [CALC_W-1:0] rounded;

  // Bytes left before the next MAX_CHUNK_BYTES boundary.
  assign room       = CALC_W'(MAX_CHUNK_BYTES) - CALC_W'(addr[OFF_W-1:0]);
  assign remain_ext = CALC_W'(remain);
  assign chunk_ext  = (remain_ext < room) ? remain_ext : room;

  // Round the chunk up to a whole number of flits.
  assign rounded = (chunk_ext + CALC_W'(NOC_DATA_BYTES - 1))
                   & ~CALC_W'(NOC_DATA_BYTES - 1);

  assign chunk  = chunk_size_t'(chunk_ext);
  assign nflits = chunk_size_t'(rounded >> NOC_PADBYTES_WIDTH);
  assign pad    = NOC_PADBYTES_WIDTH'(rounded - chunk_ext);

endmodule

// File: rtl/wr_req_splitter.sv
// wr_req_splitter
//   Splits one arbitrary-length client write request into sub-requests
//   that each stay inside one MAX_CHUNK_BYTES-aligned window, re-frames
//   the client data stream per sub-request (last/padbytes), and returns a
//   single client done once every sub-request has been acknowledged.
//   Ports:
//     clk, rst  clock and synchronous active-high reset
//     client    wr_client_if.slave : client request, data stream, done
//     split     wr_split_if.master : sub-request, data stream, sub-done
//     split_err (only with WR_SPLIT_CHECK_EN) sticky framing error flag
//   Optional feature macro: WR_SPLIT_CHECK_EN

module wr_req_splitter
  import wr_req_splitter_pkg::*;
#(
  parameter int MAX_CHUNK_BYTES = 256,
  parameter int REQ_SIZE_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  wr_client_if.slave  client,
  wr_split_if.master  split
`ifdef WR_SPLIT_CHECK_EN
  ,
  output logic        split_err
`endif
);

  wr_split_state_e               state;
  logic [MEM_ADDR_W-1:0]         addr_reg;
  logic [REQ_SIZE_W-1:0]         remain_reg;
  chunk_size_t                   chunk_reg;
  chunk_size_t                   nflits_reg;
  chunk_size_t                   flit_cnt;
  logic [NOC_PADBYTES_WIDTH-1:0] pad_reg;

  chunk_size_t                   chunk;
  chunk_size_t                   nflits;
  logic [NOC_PADBYTES_WIDTH-1:0] pad;

  logic in_stream;
  logic last_flit;
  logic data_fire;

  wr_split_chunk_calc #(
    .MAX_CHUNK_BYTES (MAX_CHUNK_BYTES),
    .REQ_SIZE_W      (REQ_SIZE_W)
  ) u_chunk_calc (
    .addr   (addr_reg),
    .remain (remain_reg),
    .chunk  (chunk),
    .nflits (nflits),
    .pad    (pad)
  );

  assign in_stream = (state == STREAM_DATA);
  assign last_flit = in_stream && (flit_cnt == nflits_reg - chunk_size_t'(1));
  assign data_fire = in_stream && client.client_wr_data_val && split.wr_split_data_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_reg   <= '0;
      remain_reg <= '0;
      chunk_reg  <= '0;
      nflits_reg <= '0;
      flit_cnt   <= '0;
      pad_reg    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (client.client_wr_req_val) begin
            addr_reg   <= client.client_wr_req_addr;
            remain_reg <= client.client_wr_req_size;
            state      <= (client.client_wr_req_size == '0) ? OUTPUT_DONE : ISSUE_REQ;
          end
        end
        ISSUE_REQ: begin
          if (split.wr_req_split_rdy) begin
            chunk_reg  <= chunk;
            nflits_reg <= nflits;
            pad_reg    <= pad;
            flit_cnt   <= '0;
            state      <= STREAM_DATA;
          end
        end
        STREAM_DATA: begin
          if (data_fire) begin
            flit_cnt <= flit_cnt + chunk_size_t'(1);
            if (last_flit) begin
              addr_reg   <= addr_reg + MEM_ADDR_W'(chunk_reg);
              remain_reg <= remain_reg - REQ_SIZE_W'(chunk_reg);
              state      <= WAIT_DONE;
            end
          end
        end
        WAIT_DONE: begin
          if (split.split_done_val) begin
            state <= (remain_reg == '0) ? OUTPUT_DONE : ISSUE_REQ;
          end
        end
        OUTPUT_DONE: begin
          if (client.client_wr_done_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake outputs decode straight from the state register; the data
  // path is gated so nothing leaks out while not streaming.
  always_comb begin
    client.wr_req_client_rdy  = (state == IDLE);
    client.wr_data_client_rdy = in_stream && split.wr_split_data_rdy;
    client.client_wr_done     = (state == OUTPUT_DONE);

    split.split_wr_req_val   = (state == ISSUE_REQ);
    split.split_wr_req_entry = '0;
    if (state == ISSUE_REQ) begin
      split.split_wr_req_entry.mem_req_addr = addr_reg;
      split.split_wr_req_entry.mem_req_size = MEM_SIZE_W'(chunk);
    end

    split.split_wr_data_val      = in_stream && client.client_wr_data_val;
    split.split_wr_data          = in_stream ? client.client_wr_data : '0;
    split.split_wr_data_last     = last_flit;
    split.split_wr_data_padbytes = last_flit ? pad_reg : '0;
    split.split_done_rdy         = (state == WAIT_DONE);
  end

`ifdef WR_SPLIT_CHECK_EN
  logic final_flit;
  logic err_set;

  // The final flit of the whole request is the last flit of the chunk
  // that drains remain_reg to zero.
  assign final_flit = last_flit && (remain_reg == REQ_SIZE_W'(chunk_reg));

  always_comb begin
    err_set = 1'b0;
    if (state == IDLE && client.client_wr_req_val &&
        !flit_aligned(client.client_wr_req_addr)) begin
      err_set = 1'b1;
    end
    if (data_fire) begin
      if (client.client_wr_data_last != final_flit) begin
        err_set = 1'b1;
      end
      if (final_flit && client.client_wr_data_padbytes != pad_reg) begin
        err_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      split_err <= 1'b0;
    end else if (err_set) begin
      split_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_wr_req_splitter.sv
// tb_wr_req_splitter
//   Directed bench for wr_req_splitter with 64-byte flits and 256-byte
//   windows. Inputs are driven on the falling edge, outputs sampled on
//   the falling edge (plus #1 where they follow inputs combinationally).

module tb_wr_req_splitter;
  import wr_req_splitter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  always #5 clk = ~clk;

  wr_client_if #(.REQ_SIZE_W(16)) client_bus ();
  wr_split_if                      split_bus ();

`ifdef WR_SPLIT_CHECK_EN
  logic split_err;
`endif

  wr_req_splitter #(
    .MAX_CHUNK_BYTES (256),
    .REQ_SIZE_W      (16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .client (client_bus),
    .split  (split_bus)
`ifdef WR_SPLIT_CHECK_EN
    ,
    .split_err (split_err)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    client_bus.client_wr_req_val       = 1'b0;
    client_bus.client_wr_req_addr      = '0;
    client_bus.client_wr_req_size      = '0;
    client_bus.client_wr_data_val      = 1'b0;
    client_bus.client_wr_data          = '0;
    client_bus.client_wr_data_last     = 1'b0;
    client_bus.client_wr_data_padbytes = '0;
    client_bus.client_wr_done_rdy      = 1'b0;
    split_bus.wr_req_split_rdy         = 1'b0;
    split_bus.wr_split_data_rdy        = 1'b0;
    split_bus.split_done_val           = 1'b0;
  endtask

  // Present one client request for a single cycle (splitter must be idle).
  task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] size);
    @(negedge clk);
    checkOutput("req_rdy_idle", 64'(client_bus.wr_req_client_rdy), 64'd1);
    client_bus.client_wr_req_val  = 1'b1;
    client_bus.client_wr_req_addr = addr;
    client_bus.client_wr_req_size = size;
    @(negedge clk);
    client_bus.client_wr_req_val = 1'b0;
  endtask

  // Wait for a sub-request, check its entry, optionally stall it a cycle
  // while poking a stray done, then accept it.
  task automatic issueCheck(input logic [31:0] addr, input logic [15:0] size,
                            input bit stall);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = split_bus.split_wr_req_val;
    end
    checkOutput("sub_req_seen", 64'(seen), 64'd1);
    if (!seen) return;
    checkOutput("sub_req_addr", 64'(split_bus.split_wr_req_entry.mem_req_addr), 64'(addr));
    checkOutput("sub_req_size", 64'(split_bus.split_wr_req_entry.mem_req_size), 64'(size));
    checkOutput("sub_req_id", 64'(split_bus.split_wr_req_entry.mem_req_id), 64'd0);
    if (stall) begin
      checkOutput("done_rdy_in_issue", 64'(split_bus.split_done_rdy), 64'd0);
      split_bus.split_done_val = 1'b1;
      @(negedge clk);
      split_bus.split_done_val = 1'b0;
      checkOutput("sub_req_held", 64'(split_bus.split_wr_req_val), 64'd1);
      checkOutput("sub_req_addr_held", 64'(split_bus.split_wr_req_entry.mem_req_addr), 64'(addr));
      checkOutput("sub_req_size_held", 64'(split_bus.split_wr_req_entry.mem_req_size), 64'(size));
    end
    split_bus.wr_req_split_rdy = 1'b1;
    @(negedge clk);
    split_bus.wr_req_split_rdy = 1'b0;
  endtask

  // Stream nflits flits; flit payloads are tagged base+index.
  task automatic streamCheck(input int nflits, input int pad, input bit isFinal,
                             input bit stall, input int base);
    int  idx = 0;
    int  cyc = 0;
    bit  cval;
    bit  drdy;
    bit  expLast;
    while (idx < nflits && cyc < 200) begin
      @(negedge clk);
      cyc++;
      cval    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      drdy    = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      expLast = (idx == nflits - 1);
      client_bus.client_wr_data_val      = cval;
      client_bus.client_wr_data          = {8{64'(base + idx)}};
      client_bus.client_wr_data_last     = isFinal && expLast;
      client_bus.client_wr_data_padbytes = (isFinal && expLast) ? 6'(pad) : 6'd0;
      split_bus.wr_split_data_rdy        = drdy;
      #1;
      checkOutput("data_val_pass", 64'(split_bus.split_wr_data_val), 64'(cval));
      checkOutput("data_rdy_pass", 64'(client_bus.wr_data_client_rdy), 64'(drdy));
      if (stall) checkOutput("req_rdy_busy", 64'(client_bus.wr_req_client_rdy), 64'd0);
      if (cval && drdy) begin
        checkOutput("flit_data", split_bus.split_wr_data[63:0], 64'(base + idx));
        checkOutput("flit_last", 64'(split_bus.split_wr_data_last), 64'(expLast));
        checkOutput("flit_pad", 64'(split_bus.split_wr_data_padbytes),
                    expLast ? 64'(pad) : 64'd0);
        idx++;
      end
    end
    checkOutput("flit_count", 64'(idx), 64'(nflits));
    @(negedge clk);
    client_bus.client_wr_data_val  = 1'b0;
    client_bus.client_wr_data_last = 1'b0;
    split_bus.wr_split_data_rdy    = 1'b0;
  endtask

  // Starts on a falling edge where client_wr_done should be high.
  task automatic finishDone(input int hold);
    for (int i = 0; i < hold; i++) begin
      checkOutput("done_hold", 64'(client_bus.client_wr_done), 64'd1);
      checkOutput("req_rdy_in_done", 64'(client_bus.wr_req_client_rdy), 64'd0);
      @(negedge clk);
    end
    checkOutput("client_done", 64'(client_bus.client_wr_done), 64'd1);
    client_bus.client_wr_done_rdy = 1'b1;
    @(negedge clk);
    client_bus.client_wr_done_rdy = 1'b0;
    checkOutput("done_cleared", 64'(client_bus.client_wr_done), 64'd0);
    checkOutput("back_idle", 64'(client_bus.wr_req_client_rdy), 64'd1);
  endtask

  task automatic doneCheck(input bit isFinal, input int hold);
    checkOutput("split_done_rdy", 64'(split_bus.split_done_rdy), 64'd1);
    checkOutput("no_early_done", 64'(client_bus.client_wr_done), 64'd0);
    split_bus.split_done_val = 1'b1;
    @(negedge clk);
    split_bus.split_done_val = 1'b0;
    if (isFinal) begin
      finishDone(hold);
    end else begin
      checkOutput("no_done_mid", 64'(client_bus.client_wr_done), 64'd0);
      checkOutput("split_done_rdy_off", 64'(split_bus.split_done_rdy), 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_req_rdy", 64'(client_bus.wr_req_client_rdy), 64'd1);
    checkOutput("rst_sub_val", 64'(split_bus.split_wr_req_val), 64'd0);
    checkOutput("rst_data_val", 64'(split_bus.split_wr_data_val), 64'd0);
    checkOutput("rst_data_rdy", 64'(client_bus.wr_data_client_rdy), 64'd0);
    checkOutput("rst_done_rdy", 64'(split_bus.split_done_rdy), 64'd0);
    checkOutput("rst_client_done", 64'(client_bus.client_wr_done), 64'd0);

    $display("[TB] single window, 128 bytes at 0x000");
    applyStimulus(32'h000, 16'd128);
    issueCheck(32'h000, 16'd128, 1'b0);
    streamCheck(2, 0, 1'b1, 1'b0, 0);
    doneCheck(1'b1, 0);

    $display("[TB] window crossing, 320 bytes at 0x0C0");
    applyStimulus(32'h0C0, 16'd320);
    issueCheck(32'h0C0, 16'd64, 1'b0);
    streamCheck(1, 0, 1'b0, 1'b0, 0);
    doneCheck(1'b0, 0);
    issueCheck(32'h100, 16'd256, 1'b0);
    streamCheck(4, 0, 1'b1, 1'b0, 1);
    doneCheck(1'b1, 0);

    $display("[TB] partial flit, 100 bytes at 0x040");
    applyStimulus(32'h040, 16'd100);
    issueCheck(32'h040, 16'd100, 1'b0);
    streamCheck(2, 28, 1'b1, 1'b0, 10);
    doneCheck(1'b1, 0);

    $display("[TB] zero-size request");
    applyStimulus(32'h300, 16'd0);
    checkOutput("zero_no_sub_req", 64'(split_bus.split_wr_req_val), 64'd0);
    finishDone(0);

    $display("[TB] stalls, 256 bytes at 0x080, done held off");
    applyStimulus(32'h080, 16'd256);
    issueCheck(32'h080, 16'd128, 1'b1);
    streamCheck(2, 0, 1'b0, 1'b1, 20);
    doneCheck(1'b0, 0);
    issueCheck(32'h100, 16'd128, 1'b1);
    streamCheck(2, 0, 1'b1, 1'b1, 22);
    doneCheck(1'b1, 5);

    $display("[TB] reset during third flit");
    applyStimulus(32'h100, 16'd256);
    issueCheck(32'h100, 16'd256, 1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      client_bus.client_wr_data_val = 1'b1;
      client_bus.client_wr_data     = {8{64'(30 + i)}};
      split_bus.wr_split_data_rdy   = 1'b1;
    end
    @(negedge clk);
    client_bus.client_wr_data = {8{64'd32}};
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_data_val", 64'(split_bus.split_wr_data_val), 64'd0);
    checkOutput("mid_rst_data_rdy", 64'(client_bus.wr_data_client_rdy), 64'd0);
    checkOutput("mid_rst_sub_val", 64'(split_bus.split_wr_req_val), 64'd0);
    checkOutput("mid_rst_done", 64'(client_bus.client_wr_done), 64'd0);
    checkOutput("mid_rst_done_rdy", 64'(split_bus.split_done_rdy), 64'd0);
    checkOutput("mid_rst_req_rdy", 64'(client_bus.wr_req_client_rdy), 64'd1);
    client_bus.client_wr_data_val = 1'b0;
    split_bus.wr_split_data_rdy   = 1'b0;

    applyStimulus(32'h200, 16'd64);
    issueCheck(32'h200, 16'd64, 1'b0);
    streamCheck(1, 0, 1'b1, 1'b0, 40);
    doneCheck(1'b1, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
